// File: rtl/lfsr_gen.sv
// lfsr_gen: configurable Fibonacci/Galois LFSR. It advances STEPS chained steps
// on each enabled cycle and reports the bit shifted out of the MSB by each step.
// A saturating counter tracks enabled cycles since the last load or reset.
// The locked flag is asserted while the register holds all zeros.
// Optional feature: define LFSR_LOCKUP_RECOVER_EN to reload RECOVER_SEED when an
// enabled cycle finds the register locked at zero. Without the macro, the
// all-zero state persists until a load or a reset.
module lfsr_gen #(
  parameter int          WIDTH        = 64,
  parameter logic [63:0] TAPS         = 64'hD800_0000_0000_0000,
  parameter logic [63:0] GPOLY        = 64'h0000_0000_0000_001B,
  parameter int          STEPS        = 1,
  parameter int          CNT_W        = 32,
  parameter logic [63:0] RECOVER_SEED = 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             enable,
  input  logic             mode,
  output logic [WIDTH-1:0] shift_seed,
  output logic [STEPS-1:0] bits_out,
  output logic [CNT_W-1:0] step_count,
  output logic             locked
);

  localparam logic [WIDTH-1:0] L_TAPS  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_GPOLY = GPOLY[WIDTH-1:0];
`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam logic [WIDTH-1:0] L_RECOVER = RECOVER_SEED[WIDTH-1:0];
`endif

  logic [WIDTH-1:0] r_state;
  logic [STEPS-1:0] r_bits;
  logic [CNT_W-1:0] r_count;
  logic             r_locked;

  logic [WIDTH-1:0] w_chain;
  logic [STEPS-1:0] w_step_bits;
  logic [WIDTH-1:0] w_next_state;
  logic [STEPS-1:0] w_next_bits;
  logic [CNT_W-1:0] w_next_count;

  // Chain STEPS single steps combinationally in the currently selected mode.
  always_comb begin
    logic [WIDTH-1:0] v_s;
    // NOTE: blocking assignments are deliberate here; each step reads the value
    // written by the previous iteration within the same evaluation.
    v_s         = r_state;
    w_step_bits = '0;
    for (int k = 0; k < STEPS; k++) begin
      w_step_bits[k] = v_s[WIDTH-1];
      if (mode) begin
        v_s = {v_s[WIDTH-2:0], 1'b0} ^ (v_s[WIDTH-1] ? L_GPOLY : '0);
      end else begin
        v_s = {v_s[WIDTH-2:0], ^(v_s & L_TAPS)};
      end
    end
    w_chain = v_s;
  end

  // Select the next register contents: load wins over enable, and idle holds.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    w_next_state = r_state;
    w_next_bits  = r_bits;
    w_next_count = r_count;
    if (load) begin
      w_next_state = seed;
      w_next_bits  = '0;
      w_next_count = '0;
    end else if (enable) begin
      w_next_count = (r_count == '1) ? r_count : r_count + CNT_W'(1);
`ifdef LFSR_LOCKUP_RECOVER_EN
      // A zero register would only shift out zeros, so bits_out clears.
      if (r_locked) begin
        w_next_state = L_RECOVER;
        w_next_bits  = '0;
      end else begin
        w_next_state = w_chain;
        w_next_bits  = w_step_bits;
      end
`else
      w_next_state = w_chain;
      w_next_bits  = w_step_bits;
`endif
    end
  end

  // State registers; reset loads the seed asynchronously, and locked tracks the next state.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (reset) begin
      r_state  <= seed;
      r_bits   <= '0;
      r_count  <= '0;
      r_locked <= (seed == '0);
    end else begin
      r_state  <= w_next_state;
      r_bits   <= w_next_bits;
      r_count  <= w_next_count;
      r_locked <= (w_next_state == '0);
    end
  end

  assign shift_seed = r_state;
  assign bits_out   = r_bits;
  assign step_count = r_count;
  assign locked     = r_locked;

endmodule
